message_sequencer: RTL

Sequences a fixed-length character message out of the registered-output message ROM and into the serial transmitter. On a start pulse it walks ROM addresses 0..MSG_LEN-1, waits out the ROM read latency, and hands each byte to the transmitter over a new_data/busy handshake. It sits between the top-level trigger logic (button/timer) and the UART TX block. It owns the ROM address bus and the transmitter input exclusively.

---
 rtl/message_sequencer_if.sv | 34 +++
 rtl/message_sequencer.sv | 116 +++++++++++
 2 files changed

// File: rtl/message_sequencer_if.sv
// rtl/message_sequencer_if.sv - ROM read port and transmitter handshake bundle
//
// Signals:
//   rom_addr  sequencer -> ROM   read address
//   rom_data  ROM -> sequencer   registered read data (one cycle after rom_addr)
//   tx_data   sequencer -> TX    byte to transmit
//   new_data  sequencer -> TX    one-cycle strobe, tx_data valid
//   tx_busy   TX -> sequencer    transmitter busy
// Modports: master = sequencer side, slave = ROM/transmitter side.
interface message_sequencer_if #(
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [7:0]            rom_data;
  logic [7:0]            tx_data;
  logic                  new_data;
  logic                  tx_busy;

  modport master (
    output rom_addr,
    output tx_data,
    output new_data,
    input  rom_data,
    input  tx_busy
  );

  modport slave (
    input  rom_addr,
    input  tx_data,
    input  new_data,
    output rom_data,
    output tx_busy
  );
endinterface

// File: rtl/message_sequencer.sv
// rtl/message_sequencer.sv - walks the message ROM and feeds each byte to the UART transmitter
//
// Ports:
//   i_clk     system clock, rising edge
//   i_rst_n   asynchronous active-low reset
//   i_start   send one message (honoured only when idle)
//   i_abort   synchronous cancel, wins over i_start
//   o_busy    high whenever a message is in progress
//   o_done    one-cycle pulse once the last byte has been taken
//   io_bus    ROM address/data and transmitter handshake (master side)
module message_sequencer #(
  parameter int MSG_LEN    = 14,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_abort,
  output logic                 o_busy,
  output logic                 o_done,
  message_sequencer_if.master  io_bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_GUARD,
    S_WAIT_TX
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MSG_LEN - 1);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_tx_data;
  logic                  r_new_data;
  logic                  r_done;

  logic                  w_last;
  logic                  w_load;
  logic                  w_step;
  logic                  w_finish;

  assign w_last = (r_addr == LAST_ADDR);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_start) w_next = S_FETCH;
        S_FETCH:   w_next = S_SEND;
        S_SEND:    if (!io_bus.tx_busy) w_next = S_GUARD;
        // GUARD gives the transmitter a cycle to raise tx_busy after the strobe
        S_GUARD:   w_next = S_WAIT_TX;
        S_WAIT_TX: if (!io_bus.tx_busy) w_next = w_last ? S_IDLE : S_FETCH;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  // Output / datapath-control decode
  always_comb begin
    o_busy   = (r_state != S_IDLE);
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    if (!i_abort) begin
      w_load   = (r_state == S_SEND)    && !io_bus.tx_busy;
      w_step   = (r_state == S_WAIT_TX) && !io_bus.tx_busy && !w_last;
      w_finish = (r_state == S_WAIT_TX) && !io_bus.tx_busy &&  w_last;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr     <= '0;
      r_tx_data  <= 8'h00;
      r_new_data <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      // Strobe lasts exactly one cycle: it is only set on the SEND->GUARD edge
      r_new_data <= w_load;
      r_done     <= w_finish;
      if (w_load) begin
        r_tx_data <= io_bus.rom_data;
      end
      // Address returns to 0 on completion or abort, so IDLE always sits at 0
      if (i_abort || w_finish) begin
        r_addr <= '0;
      end else if (w_step) begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign io_bus.rom_addr = r_addr;
  assign io_bus.tx_data  = r_tx_data;
  assign io_bus.new_data = r_new_data;
  assign o_done          = r_done;

endmodule
